// File: rtl/alu_seq_ctrl.sv
// Operation sequencer for disp_ALU: accepts an operand/op request, then shows one op
// (or sweeps all four) for DWELL cycles each, driving the ALU op/enable.
module alu_seq_ctrl #(
    parameter int unsigned DWELL = 50000000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_req_valid,
    output logic       o_req_ready,
    input  logic [2:0] i_req_a,
    input  logic [2:0] i_req_b,
    input  logic [1:0] i_req_op,
    input  logic       i_req_sweep,
    input  logic       i_hold,
    input  logic       i_abort,
    output logic [2:0] o_alu_a,
    output logic [2:0] o_alu_b,
    output logic [1:0] o_alu_op,
    output logic       o_alu_en,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    typedef enum logic {StIdle, StShow} state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_sweep;
    logic [2:0]    r_alu_a;
    logic [2:0]    r_alu_b;
    logic [1:0]    r_alu_op;
    logic          r_alu_en;
    logic          r_busy;
    logic          r_done;

    // Ready is the only combinational output so a request can land on the done cycle.
    assign o_req_ready = (r_state == StIdle) && !i_rst;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_sweep  <= 1'b0;
            r_alu_a  <= 3'd0;
            r_alu_b  <= 3'd0;
            r_alu_op <= 2'd0;
            r_alu_en <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_state  <= StShow;
                        r_alu_a  <= i_req_a;
                        r_alu_b  <= i_req_b;
                        r_sweep  <= i_req_sweep;
                        r_alu_op <= i_req_sweep ? 2'd0 : i_req_op;
                        r_cnt    <= '0;
                        r_alu_en <= 1'b1;
                        r_busy   <= 1'b1;
                    end
                end
                StShow: begin
                    if (i_abort) begin
                        r_state  <= StIdle;
                        r_alu_en <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (i_hold) begin
                        r_cnt <= r_cnt;
                    end else if (r_cnt != LAST) begin
                        r_cnt <= r_cnt + 1'b1;
                    end else if (r_sweep && (r_alu_op != 2'd3)) begin
                        r_alu_op <= r_alu_op + 2'd1;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= StIdle;
                        r_alu_en <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_alu_a  = r_alu_a;
    assign o_alu_b  = r_alu_b;
    assign o_alu_op = r_alu_op;
    assign o_alu_en = r_alu_en;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl (DWELL=4): directed scenarios plus random traffic,
// compared every cycle against a remaining-cycles reference model.
module tb_alu_seq_ctrl;

    localparam int unsigned DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_a;
    logic [2:0] req_b;
    logic [1:0] req_op;
    logic       req_sweep;
    logic       hold;
    logic       abort;
    logic [2:0] alu_a;
    logic [2:0] alu_b;
    logic [1:0] alu_op;
    logic       alu_en;
    logic       busy;
    logic       done;

    always #5 clk = ~clk;

    alu_seq_ctrl #(.DWELL(DWELL)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .i_req_op    (req_op),
        .i_req_sweep (req_sweep),
        .i_hold      (hold),
        .i_abort     (abort),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_alu_en    (alu_en),
        .o_busy      (busy),
        .o_done      (done)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: a run is "active" with m_left cycles still to show for the current op.
    bit       m_active = 1'b0;
    bit       m_sweep  = 1'b0;
    int       m_left   = 0;
    bit [2:0] m_a      = 3'd0;
    bit [2:0] m_b      = 3'd0;
    int       m_op     = 0;
    bit       m_done   = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_active = 0; m_sweep = 0; m_left = 0;
            m_a = 0; m_b = 0; m_op = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (!m_active) begin
                if (req_valid) begin
                    m_active = 1;
                    m_a      = req_a;
                    m_b      = req_b;
                    m_sweep  = req_sweep;
                    m_op     = req_sweep ? 0 : int'(req_op);
                    m_left   = DWELL;
                end
            end else if (abort) begin
                m_active = 0;
            end else if (!hold) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_sweep && m_op < 3) begin
                        m_op++;
                        m_left = DWELL;
                    end else begin
                        m_active = 0;
                        m_done   = 1;
                    end
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        chk("req_ready", int'(req_ready), int'(!m_active && !rst));
        @(posedge clk);
        model_edge();
        #1;
        chk("alu_a", int'(alu_a), int'(m_a));
        chk("alu_b", int'(alu_b), int'(m_b));
        chk("alu_op", int'(alu_op), m_op);
        chk("alu_en", int'(alu_en), int'(m_active));
        chk("busy", int'(busy), int'(m_active));
        chk("done", int'(done), int'(m_done));
    endtask

    task automatic request(input logic [2:0] a, input logic [2:0] b, input logic [1:0] op,
                           input logic sweep);
        req_a = a; req_b = b; req_op = op; req_sweep = sweep; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Counts enabled cycles until done is seen; a missing done is reported as a failure.
    task automatic run_to_done(output int en_cycles);
        bit seen = 1'b0;
        en_cycles = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (alu_en) en_cycles++;
            tick();
        end
        chk("done_seen", int'(seen), 1);
    endtask

    int n_en;
    int n_op1;
    int hc;
    int en_at_done;

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
        req_sweep = 1'b0; hold = 1'b0; abort = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // Reset mid-sweep for two cycles.
        request(3'd7, 3'd6, 2'd3, 1'b1);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        tick(); tick();
        chk("rst_op", int'(alu_op), 0);
        chk("rst_a", int'(alu_a), 0);
        chk("rst_en", int'(alu_en), 0);
        rst = 1'b0;
        tick();

        // Single run.
        request(3'b101, 3'b011, 2'b10, 1'b0);
        chk("single_a", int'(alu_a), 5);
        chk("single_op", int'(alu_op), 2);
        run_to_done(n_en);
        chk("single_en_cycles", n_en, 4);
        tick();
        chk("single_done_width", int'(done), 0);
        chk("single_op_idle", int'(alu_op), 2);

        // Sweep ignoring req_op.
        request(3'd2, 3'd3, 2'b11, 1'b1);
        chk("sweep_first_op", int'(alu_op), 0);
        run_to_done(n_en);
        chk("sweep_en_cycles", n_en, 16);
        tick();

        // Sweep with hold for three cycles during op 01.
        request(3'd1, 3'd4, 2'b00, 1'b1);
        n_en = 0; n_op1 = 0; hc = 0;
        for (int i = 0; i < 80; i++) begin
            if (done) break;
            if (alu_en) n_en++;
            if (alu_en && alu_op == 2'd1) n_op1++;
            hold = (alu_op == 2'd1) && (hc < 3);
            if (hold) hc++;
            tick();
        end
        hold = 1'b0;
        chk("hold_done", int'(done), 1);
        chk("hold_op1_cycles", n_op1, 7);
        chk("hold_en_cycles", n_en, 19);
        tick();

        // Abort on the last dwell cycle of op 11.
        request(3'd3, 3'd3, 2'b01, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        chk("abort_pre_op", int'(alu_op), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_en", int'(alu_en), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_op", int'(alu_op), 3);
        tick(); tick();

        // Handshake: valid during SHOW ignored; request on done cycle accepted.
        request(3'd1, 3'd2, 2'b00, 1'b0);
        req_valid = 1'b1; req_a = 3'd7; req_b = 3'd7; req_op = 2'd3;
        for (int i = 0; i < 20; i++) begin
            if (done) break;
            tick();
        end
        chk("hs_ignored_a", int'(alu_a), 1);
        en_at_done = int'(alu_en);
        chk("hs_gap_en", en_at_done, 0);
        req_a = 3'd6; req_b = 3'd4; req_op = 2'd1;
        tick();
        req_valid = 1'b0;
        chk("hs_accept_en", int'(alu_en), 1);
        chk("hs_accept_a", int'(alu_a), 6);
        run_to_done(n_en);
        chk("hs_en_cycles", n_en, 4);
        tick();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_a     = 3'($urandom);
            req_b     = 3'($urandom);
            req_op    = 2'($urandom);
            req_sweep = 1'($urandom_range(0, 1));
            hold      = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 63) == 0);
            tick();
        end
        rst = 1'b0; req_valid = 1'b0; hold = 1'b0; abort = 1'b0;
        for (int i = 0; i < 20; i++) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Operation sequencer that drives the 3-bit ALU / seven-segment display block (`disp_ALU`). It accepts an operand pair and an operation request over a valid/ready handshake, then either presents one operation for a fixed dwell time or sweeps all four operations (XNOR, shift, add, multiply) in order, one dwell period each. It sits between the operand/switch input logic and `disp_ALU`, owning that block's `op` and `en` inputs.

## Interface
- `DWELL`, default 50000000: cycles each operation is presented (1 s at 50 MHz); legal range ≥ 1. The internal counter is ceil(log2(DWELL+1)) bits wide.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: **one clock; reset is synchronous and active-high**.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller can accept; high only in IDLE and low while `rst` is high.
- `req_a`  in  3  operand A.
- `req_b`  in  3  operand B.
- `req_op`  in  2  operation for single mode: 00 xnor, 01 shift, 10 add, 11 mult.
- `req_sweep`  in  1  1 = sweep 00→11, ignoring `req_op`.
- `hold`  in  1  freezes the dwell counter; the current op stays displayed.
- `abort`  in  1  ends the active run without `done`.
- `alu_a`, `alu_b`  out  3  latched operands for the datapath.
- `alu_op`  out  2  to `disp_ALU.op`.
- `alu_en`  out  1  to `disp_ALU.en`.
- `busy`  out  1  high in SHOW.
- `done`  out  1  one-cycle pulse when a run completes normally.

## Operation
- States: IDLE, SHOW.
- IDLE: `alu_en`=0 and `busy`=0. `alu_a`, `alu_b` and `alu_op` keep their last values.
- IDLE → SHOW when `req_valid & req_ready`. The same edge:
  - latches `req_a`, `req_b` and `req_sweep`;
  - sets `alu_op` = `req_sweep` ? 00 : `req_op`;
  - clears the counter;
  - sets `alu_en`=1 and `busy`=1.
- SHOW, each cycle:
  - `abort`=1 → IDLE next edge; `done` stays 0.
  - else if `hold`=1 → counter unchanged.
  - else if counter ≠ DWELL-1 → counter+1.
  - else if sweep mode and `alu_op` ≠ 11 → `alu_op`+1 (no wrap) and counter cleared; stay in SHOW.
  - else → IDLE, with `done`=1 for exactly one cycle.
- Priority: `rst` > `abort` > `hold` > dwell expiry.
- `req_valid` outside IDLE is ignored. The requester must hold the request until it sees `req_ready`.
- `req_ready` is combinational: state==IDLE and not `rst`. All other outputs are registered.
- Reset (any time, including mid-SHOW) forces on the next edge: state IDLE, `alu_a`=0, `alu_b`=0, `alu_op`=00, `alu_en`=0, `busy`=0, `done`=0, counter 0.

## Timing
- Request accepted at edge E0 → `alu_en`/`alu_op` valid from E0 (zero-cycle output latency after acceptance).
- Single mode: `alu_en` high for exactly DWELL cycles. `done`=1 and `alu_en`=0 after edge E0+DWELL.
- Sweep mode: `alu_op` changes at E0+DWELL, E0+2·DWELL and E0+3·DWELL. `done` follows E0+4·DWELL.
- Each `hold` cycle in SHOW extends the current op by one cycle.
- `done` coincides with `req_ready`=1, so a new request can be accepted on the `done` cycle. The minimum gap between runs is therefore one cycle with `alu_en`=0.
- DWELL=1: each op is shown for one cycle; sweep takes 4 cycles.
- Abort on the final dwell cycle: abort wins, so no `done` and no op increment.

## Test plan (DWELL=4)
- **Reset:** assert `rst` for 2 cycles mid-sweep → all outputs 0 and `alu_op`=00 after the edge. `req_ready` is 0 during reset and 1 the cycle after release.
- **Single run:** `req_a`=101, `req_b`=011, `req_op`=10, `req_sweep`=0 → `alu_a`=101, `alu_b`=011, `alu_op`=10. `alu_en`/`busy` high for 4 cycles, then a `done` pulse of 1 cycle. `alu_op` stays 10 in IDLE.
- **Sweep:** `req_sweep`=1 with `req_op`=11 → `alu_op` sequence 00,01,10,11 for 4 cycles each, then `done` after 16 cycles.
- **Hold:** during sweep, `hold`=1 for 3 cycles while `alu_op`=01 → op 01 shown for 7 cycles; `done` after 19 cycles.
- **Abort:** `abort` on the 4th cycle of op 11 in sweep → IDLE next edge, `done` never asserted, `alu_op` stays 11.
- **Handshake:** `req_valid` held high during SHOW with different operands → ignored and `alu_a` unchanged. A new request presented on the `done` cycle → accepted, with `alu_en` low for exactly one cycle between runs.
